// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with a one-entry skid buffer, valid/ready handshake and flush-to-NOP.
// Optional performance counters (stall/bubble) are compiled in when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             main_v_q, main_v_d;
  logic [WIDTH-1:0] main_d_q, main_d_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_d_q, skid_d_d;
  logic             in_ready_q, in_ready_d;
  logic             in_tx;
  logic             out_tx;

  assign in_tx  = in_valid & in_ready_q;
  assign out_tx = main_v_q & out_ready;

  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    if (flush) begin
      // A flush empties both entries; any word offered this cycle is dropped.
      main_v_d = 1'b0;
      main_d_d = NOP_VALUE;
      skid_v_d = 1'b0;
      skid_d_d = NOP_VALUE;
    end else begin
      case ({main_v_q, skid_v_q})
        2'b00: begin
          if (in_tx) begin
            main_v_d = 1'b1;
            main_d_d = in_data;
          end
        end
        2'b10: begin
          if (in_tx && out_tx) begin
            main_d_d = in_data;
          end else if (in_tx) begin
            skid_v_d = 1'b1;
            skid_d_d = in_data;
          end else if (out_tx) begin
            main_v_d = 1'b0;
            main_d_d = NOP_VALUE;
          end
        end
        2'b11: begin
          // in_ready is low here, so only the drain of main can happen.
          if (out_tx) begin
            main_d_d = skid_d_q;
            skid_v_d = 1'b0;
            skid_d_d = NOP_VALUE;
          end
        end
        default: begin
          main_v_d = 1'b0;
          main_d_d = NOP_VALUE;
          skid_v_d = 1'b0;
          skid_d_d = NOP_VALUE;
        end
      endcase
    end
    in_ready_d = ~skid_v_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      main_v_q   <= 1'b0;
      main_d_q   <= NOP_VALUE;
      skid_v_q   <= 1'b0;
      skid_d_q   <= NOP_VALUE;
      in_ready_q <= 1'b1;
    end else begin
      main_v_q   <= main_v_d;
      main_d_q   <= main_d_d;
      skid_v_q   <= skid_v_d;
      skid_d_q   <= skid_d_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_data  = main_d_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters, observed from the registered outputs; only reset clears them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_v_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (!main_v_q && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
